fibonacci_seq_calc: RTL and testbench
=====================================

FIBONACCI_SEQ_CALC -- requirements
Module: fibonacci_seq_calc

Interface
REQ-001 Parameter DATA_W, default 16, result width in bits (legal 8..64).
REQ-002 Parameter IDX_W, default 5, sequence index width; max index 2**IDX_W-1.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 begin_fibo  in  1  start request, sampled on clk.
REQ-007 input_s  in  IDX_W  sequence index n, sampled with begin_fibo.
REQ-008 mode  in  1  0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1), sampled with begin_fibo.
REQ-009 busy  out  1  high while a computation is in progress.
REQ-010 done  out  1  level; high while result is valid.
REQ-011 fibo_out  out  DATA_W  term n of the selected sequence, saturated.
REQ-012 overflow  out  1  high with done when the true term exceeds 2**DATA_W-1.

Function
REQ-013 The FSM shall have states IDLE, CALC, DONE.
REQ-014 In IDLE or DONE, begin_fibo=1 shall latch input_s and mode, load a=seed0, b=seed1 (tags clear), cnt=0, clear done, and enter CALC.
REQ-015 In CALC, if cnt==latched n: fibo_out<=a, overflow<=tag(a), go to DONE; else a<=b, b<=sat(a+b), cnt<=cnt+1.
REQ-016 The start-sampling edge shall be cycle 0; done shall rise after edge n+1 (n=0 -> done after edge 1).
REQ-017 busy shall equal (state==CALC); done shall equal (state==DONE); never both high.
REQ-018 begin_fibo while in CALC shall be ignored; latched n/mode unchanged.
REQ-019 DONE shall hold fibo_out/overflow stable indefinitely until the next accepted begin_fibo or reset.
REQ-020 begin_fibo in DONE shall restart on that edge; done drops the following cycle.
REQ-021 The sum a+b shall be computed DATA_W+1 wide; on carry, or if either operand tag is set, b shall become 2**DATA_W-1 with tag set.
REQ-022 Tags shall move with their operands (a's tag takes b's tag on shift), so overflow is exact: asserted iff true term > 2**DATA_W-1.
REQ-023 cnt shall be IDX_W wide; compare precedes increment, so n=2**IDX_W-1 shall complete with no wrap.
REQ-024 Fibonacci: F(0)=0, F(1)=1; Lucas: L(0)=2, L(1)=1.

Reset
REQ-025 reset_n low shall force IDLE, busy=0, done=0, fibo_out=0, overflow=0, a=b=cnt=0, tags clear, asynchronously.
REQ-026 Reset asserted mid-CALC shall abort the computation; no done pulse follows release.
REQ-027 Release shall be synchronised externally; first begin_fibo accepted on the first edge after release.

Structure
REQ-028 Package fib_pkg shall hold the state enum (IDLE, CALC, DONE), the mode enum (MODE_FIB, MODE_LUCAS), and seed constants per mode.
REQ-029 One sub-module fib_sat_add (combinational, DATA_W param) shall implement the tagged saturating add of REQ-021.
REQ-030 Total RTL 120-400 lines; no multipliers, no memories.

Verification
REQ-031 DATA_W=16, mode 0, n=0..24 each after reset -> fibo_out matches F(n) (F(23)=28657, F(24)=46368), overflow=0, done after n+1 edges.
REQ-032 DATA_W=16, mode 0, n=25 -> fibo_out=65535, overflow=1; n=31 -> 65535, overflow=1.
REQ-033 DATA_W=16, mode 1, n=0,1,10 -> 2, 1, 123; n=23 -> 64079, overflow=0; n=24 -> 65535, overflow=1.
REQ-034 Start n=20, pulse begin_fibo n=3 at cycle 5 -> ignored, result 6765 at edge 21.
REQ-035 Start n=20, assert reset_n low at cycle 8 -> outputs zero immediately, IDLE, no done after release.
REQ-036 Back-to-back: in DONE with n=5 (5), begin_fibo n=6 -> done low next cycle, result 8 after 7 edges.

Source files
------------

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and seed constants for the Fibonacci/Lucas calculator
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_FIB   = 1'b0,
        MODE_LUCAS = 1'b1
    } mode_t;

    localparam logic [63:0] FIB_SEED0   = 64'd0;
    localparam logic [63:0] FIB_SEED1   = 64'd1;
    localparam logic [63:0] LUCAS_SEED0 = 64'd2;
    localparam logic [63:0] LUCAS_SEED1 = 64'd1;

    function automatic logic [63:0] seed0(input mode_t m);
        return (m == MODE_LUCAS) ? LUCAS_SEED0 : FIB_SEED0;
    endfunction

    function automatic logic [63:0] seed1(input mode_t m);
        return (m == MODE_LUCAS) ? LUCAS_SEED1 : FIB_SEED1;
    endfunction

endpackage

// File: rtl/fib_sat_add.sv
// rtl/fib_sat_add.sv - tagged saturating adder for sequence terms
//   a, b         : operands (DATA_W)
//   a_tag, b_tag : operand already saturated (true value exceeds range)
//   sum          : a+b, or all-ones when saturated
//   sum_tag      : result saturated
module fib_sat_add #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_tag,
    input  logic              b_tag,
    output logic [DATA_W-1:0] sum,
    output logic              sum_tag
);

    logic [DATA_W:0] wide_sum;

    // A tagged operand already stands for a value above the range, so any sum
    // involving it is also out of range regardless of the carry.
    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        sum_tag  = wide_sum[DATA_W] | a_tag | b_tag;
        sum      = sum_tag ? {DATA_W{1'b1}} : wide_sum[DATA_W-1:0];
    end

endmodule

// File: rtl/fibonacci_seq_calc.sv
// rtl/fibonacci_seq_calc.sv - iterative Fibonacci/Lucas term calculator with saturation
//   clk, reset_n : clock, asynchronous active-low reset
//   begin_fibo   : start request; input_s (index n) and mode sampled with it
//   busy         : computation in progress
//   done         : result valid (level, held until next accepted start)
//   fibo_out     : term n, saturated to all-ones
//   overflow     : true term exceeds 2**DATA_W-1
module fibonacci_seq_calc
    import fib_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              begin_fibo,
    input  logic [IDX_W-1:0]  input_s,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] fibo_out,
    output logic              overflow
);

    state_t             state;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic               a_tag;
    logic               b_tag;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   n_lat;
    logic [DATA_W-1:0]  sum;
    logic               sum_tag;

    fib_sat_add #(.DATA_W(DATA_W)) u_add (
        .a       (a),
        .b       (b),
        .a_tag   (a_tag),
        .b_tag   (b_tag),
        .sum     (sum),
        .sum_tag (sum_tag)
    );

    // Both flags decode straight from the state register, so they can never
    // be high together.
    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            a_tag    <= 1'b0;
            b_tag    <= 1'b0;
            cnt      <= '0;
            n_lat    <= '0;
            fibo_out <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (begin_fibo) begin
                        n_lat <= input_s;
                        a     <= DATA_W'(seed0(mode_t'(mode)));
                        b     <= DATA_W'(seed1(mode_t'(mode)));
                        a_tag <= 1'b0;
                        b_tag <= 1'b0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Compare before increment: the last index finishes without
                    // the counter ever wrapping.
                    if (cnt == n_lat) begin
                        fibo_out <= a;
                        overflow <= a_tag;
                        state    <= DONE;
                    end else begin
                        a     <= b;
                        a_tag <= b_tag;
                        b     <= sum;
                        b_tag <= sum_tag;
                        cnt   <= cnt + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_seq_calc.sv
// tb/tb_fibonacci_seq_calc.sv - self-checking bench for fibonacci_seq_calc
module tb_fibonacci_seq_calc;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;
    localparam longint MAXV = 65535;

    logic              clk;
    logic              reset_n;
    logic              begin_fibo;
    logic [IDX_W-1:0]  input_s;
    logic              mode;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] fibo_out;
    logic              overflow;

    typedef struct {
        logic [DATA_W-1:0] val;
        logic              ovf;
        int                lat;
        int                n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    fibonacci_seq_calc #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .begin_fibo (begin_fibo),
        .input_s    (input_s),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .fibo_out   (fibo_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint true_term(input int n, input bit lucas);
        longint x = lucas ? 2 : 0;
        longint y = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        begin_fibo = 1'b0;
        reset_n    = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
    endtask

    // Drives a start so that the next rising edge (edge 0) samples it, and
    // pushes the model's expectation.
    task automatic start(input int n, input bit m);
        exp_t e;
        longint t;
        t     = true_term(n, m);
        e.val = (t > MAXV) ? DATA_W'(MAXV) : DATA_W'(t);
        e.ovf = (t > MAXV);
        e.lat = n + 1;
        e.n   = n;
        sb.push_back(e);
        @(negedge clk);
        begin_fibo = 1'b1;
        input_s    = IDX_W'(n);
        mode       = m;
        @(posedge clk);
        #1;
        begin_fibo = 1'b0;
    endtask

    // Waits for done starting at edge 'from', checking busy along the way,
    // then pops the scoreboard and compares.
    task automatic wait_check(input int from);
        exp_t e;
        int   e_at = -1;
        int   k    = from;
        bit   busy_ok = 1'b1;
        while (k < from + 80) begin
            @(posedge clk);
            k++;
            #1;
            if (done) begin
                e_at = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        e = sb.pop_front();
        checks++;
        if (e_at !== e.lat) $display("FAIL latency n=%0d got edge %0d need %0d", e.n, e_at, e.lat);
        else passed++;
        checks++;
        if (fibo_out !== e.val) $display("FAIL fibo_out n=%0d got %0d need %0d", e.n, fibo_out, e.val);
        else passed++;
        checks++;
        if (overflow !== e.ovf) $display("FAIL overflow n=%0d got %0b need %0b", e.n, overflow, e.ovf);
        else passed++;
        checks++;
        if (busy_ok !== 1'b1 || busy !== 1'b0)
            $display("FAIL busy n=%0d calc_ok %0b at_done %0b need 1/0", e.n, busy_ok, busy);
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow} !== 3'b000 || fibo_out !== '0)
            $display("FAIL reset_state got busy %0b done %0b ovf %0b out %0d need all 0", busy, done, overflow, fibo_out);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fib_sweep();
        for (int n = 0; n < 32; n++) begin
            apply_reset();
            start(n, 1'b0);
            wait_check(0);
        end
    endtask

    task automatic test_lucas();
        int ns[6] = '{0, 1, 10, 23, 24, 31};
        foreach (ns[i]) begin
            apply_reset();
            start(ns[i], 1'b1);
            wait_check(0);
        end
    endtask

    task automatic test_ignore_mid_calc();
        apply_reset();
        start(20, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        begin_fibo = 1'b1;
        input_s    = IDX_W'(3);
        mode       = 1'b1;
        @(posedge clk);
        #1;
        begin_fibo = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL ignore_busy got %0b need 1", busy);
        else passed++;
        wait_check(5);
    endtask

    task automatic test_reset_mid_calc();
        bit seen_done = 1'b0;
        apply_reset();
        start(20, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow} !== 3'b000 || fibo_out !== '0)
            $display("FAIL abort_state got busy %0b done %0b ovf %0b out %0d need all 0", busy, done, overflow, fibo_out);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) $display("FAIL abort_no_done got activity %0b need 0", seen_done);
        else passed++;
        void'(sb.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] held;
        bit stable = 1'b1;
        apply_reset();
        start(5, 1'b0);
        wait_check(0);
        held = fibo_out;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!done || fibo_out !== held || overflow !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) $display("FAIL done_hold got stable %0b need 1", stable);
        else passed++;
        start(6, 1'b0);
        checks++;
        if (done !== 1'b0) $display("FAIL restart_done_drop got %0b need 0", done);
        else passed++;
        wait_check(0);
    endtask

    initial begin
        reset_n    = 1'b1;
        begin_fibo = 1'b0;
        input_s    = '0;
        mode       = 1'b0;
        test_reset();
        test_fib_sweep();
        test_lucas();
        test_ignore_mid_calc();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
